multicycle_addsub: RTL and testbench
====================================

Name: multicycle_addsub

Overview:
- Parametrised, multi-cycle integer adder/subtractor for the datapath.
- Processes CHUNK bits per clock, LSB chunk first, through a single CHUNK-bit ripple stage, trading latency for area.
- Adds a start/busy/done handshake, a subtract mode using the carry-in-as-+1 two's-complement trick, and carry/overflow/zero flags.
- Sits beside the ALU as the shared arithmetic unit for wide or multi-cycle operations.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per clock; NCHUNK = WIDTH/CHUNK, which must be 1 or more.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only when busy=0
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  first operand; sampled with start
- b  input  WIDTH  second operand; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result/flags update
- result  output  WIDTH  last completed sum/difference
- carry_out  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  result == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0.
  - Internal operand, accumulator and chunk counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at a rising edge:
  - Latch A=a and B = sub ? ~b : b.
  - Set running carry = sub, chunk index = 0.
  - Go to RUN.
- IDLE or DONE, start=0: go to or stay in IDLE.
- RUN, each edge:
  - Add chunk index i: A[i*CHUNK +: CHUNK] + B[i*CHUNK +: CHUNK] + carry.
  - Write the CHUNK sum bits into the accumulator; update the running carry.
- RUN, at chunk NCHUNK-1:
  - Also record the carry into the MSB for the overflow calculation.
  - Go to DONE.
- Register update on the final RUN edge:
  - result = full accumulator including the last chunk.
  - carry_out = final carry.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero = (new result == 0).
- busy = 1 exactly while state == RUN; done = 1 exactly while state == DONE.
- Latency: start sampled at edge k; busy is high for NCHUNK cycles; done is high in the cycle after edge k+NCHUNK, for one cycle only.
- Back-to-back: start asserted during the DONE cycle is accepted, so there is no idle bubble. Throughput is one operation per NCHUNK+1 cycles.
- start while busy=1 is ignored entirely. Operand and sub changes during RUN have no effect.
- result and flags hold their values between completions; they change only on the final RUN edge.
- Reset mid-RUN aborts the operation: no done pulse, and all outputs return to reset values.
- Widths and flags:
  - Arithmetic is modulo 2^WIDTH.
  - sub with b=0 gives result=a and carry_out=1.
  - a-b with a<b (unsigned) gives carry_out=0.
- NCHUNK = 1: a single RUN cycle, latency 1.

Test Plan:
- Reset and idle: assert rst_n=0 mid-simulation, release, start=0 for 10 cycles -> all outputs 0, busy never asserted.
- Add (WIDTH=32, CHUNK=8): a=0x0000_00FF, b=0x0000_0001, sub=0 -> busy for 4 cycles, then done pulse; result=0x0000_0100, carry_out=0, overflow=0, zero=0.
- Sub with borrow and zero: 5-7 -> result=0xFFFF_FFFE, carry_out=0, overflow=0. Next, 0x1234_5678-0x1234_5678 -> result=0, zero=1, carry_out=1.
- Overflow and carry:
  - 0x7FFF_FFFF+1 -> result=0x8000_0000, overflow=1, carry_out=0.
  - 0xFFFF_FFFF+1 -> result=0, carry_out=1, overflow=0, zero=1.
  - 0x8000_0000-1 -> result=0x7FFF_FFFF, overflow=1.
- Handshake:
  - start held high continuously -> operations complete every 5 cycles.
  - Operand changes and start pulses during RUN are ignored; result matches operands latched at acceptance.
- Reset mid-RUN and parametrisation:
  - rst_n low on the 2nd RUN cycle -> no done; outputs 0; a new start then completes normally.
  - Rerun the add/sub cases with WIDTH=16/CHUNK=16 and WIDTH=64/CHUNK=4 -> latencies of 1 and 16 cycles respectively; results match the reference model.

Source files
------------

// File: rtl/multicycle_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple stage reused per clock,
// LSB chunk first, with start/busy/done handshake and carry/overflow/zero flags.
module multicycle_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [IW-1:0]    idx;

    int unsigned      base;
    logic [CHUNK-1:0] a_chk;
    logic [CHUNK-1:0] b_chk;
    logic [CHUNK:0]   sum;
    logic             msb_cin;
    logic             last;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        base  = 32'(idx) * 32'(CHUNK);
        a_chk = CHUNK'(op_a >> base);
        b_chk = CHUNK'(op_b >> base);
        sum   = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry};
        // sum bit = a ^ b ^ cin, so the carry into the top bit falls out directly
        msb_cin  = sum[CHUNK-1] ^ a_chk[CHUNK-1] ^ b_chk[CHUNK-1];
        last     = (idx == LAST_IDX);
        acc_next = (acc & ~(CHUNK_MASK << base))
                 | (WIDTH'(sum[CHUNK-1:0]) << base);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= sum[CHUNK];
                    if (last) begin
                        result    <= acc_next;
                        carry_out <= sum[CHUNK];
                        overflow  <= msb_cin ^ sum[CHUNK];
                        zero      <= (acc_next == '0);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Scoreboard bench for multicycle_addsub at 32/8, 16/16 and 64/4.
// Stimulus pushes expected responses; a monitor pops them on each done pulse.
module tb_multicycle_addsub;

    typedef struct packed {
        logic [1:0]  sel;
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v;
    logic        sub_bus;
    logic [63:0] a_bus;
    logic [63:0] b_bus;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  c_v;
    logic [2:0]  v_v;
    logic [2:0]  z_v;
    logic [31:0] r32;
    logic [15:0] r16;
    logic [63:0] r64;
    logic [63:0] res_v [3];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   lat_tab [3] = '{5, 2, 17};
    exp_t sbq [$];
    exp_t me;

    assign res_v[0] = {32'd0, r32};
    assign res_v[1] = {48'd0, r16};
    assign res_v[2] = r64;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    multicycle_addsub #(.WIDTH(32), .CHUNK(8)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_bus),
        .a(a_bus[31:0]), .b(b_bus[31:0]), .busy(busy_v[0]),
        .done(done_v[0]), .result(r32), .carry_out(c_v[0]),
        .overflow(v_v[0]), .zero(z_v[0])
    );

    multicycle_addsub #(.WIDTH(16), .CHUNK(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_bus),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .busy(busy_v[1]),
        .done(done_v[1]), .result(r16), .carry_out(c_v[1]),
        .overflow(v_v[1]), .zero(z_v[1])
    );

    multicycle_addsub #(.WIDTH(64), .CHUNK(4)) u_w64 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_bus),
        .a(a_bus), .b(b_bus), .busy(busy_v[2]),
        .done(done_v[2]), .result(r64), .carry_out(c_v[2]),
        .overflow(v_v[2]), .zero(z_v[2])
    );

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (done_v[i]) begin
                    total++;
                    if (sbq.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_done dut=%0d got=%0h exp=none",
                                 i, res_v[i]);
                    end else begin
                        me = sbq.pop_front();
                        if (me.sel != 2'(i) || res_v[i] != me.r ||
                            c_v[i] != me.c || v_v[i] != me.v ||
                            z_v[i] != me.z) begin
                            bad++;
                            $display("FAIL result dut=%0d got=%0h c=%0b v=%0b z=%0b exp dut=%0d %0h c=%0b v=%0b z=%0b",
                                     i, res_v[i], c_v[i], v_v[i], z_v[i],
                                     me.sel, me.r, me.c, me.v, me.z);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic all_zero(input int i);
        return (busy_v[i] | done_v[i] | c_v[i] | v_v[i] | z_v[i]) == 1'b0
               && res_v[i] == 64'd0;
    endfunction

    task automatic push(input int sel, input logic [63:0] r,
                        input logic c, input logic v);
        exp_t e;
        e.sel = 2'(sel);
        e.r   = r;
        e.c   = c;
        e.v   = v;
        e.z   = (r == 64'd0);
        sbq.push_back(e);
    endtask

    task automatic run_op(input int sel, input logic [63:0] av,
                          input logic [63:0] bv, input logic sv,
                          input logic [63:0] er, input logic ec,
                          input logic ev);
        int n;
        logic seen;
        @(negedge clk);
        a_bus = av;
        b_bus = bv;
        sub_bus = sv;
        start_v[sel] = 1'b1;
        push(sel, er, ec, ev);
        @(posedge clk);
        #1 start_v[sel] = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = done_v[sel];
        end
        check($sformatf("latency dut=%0d", sel), 64'(n), 64'(lat_tab[sel]));
        @(negedge clk);
        check($sformatf("done_pulse dut=%0d", sel), 64'(done_v[sel]), 64'd0);
    endtask

    initial begin
        int   n;
        int   prev;
        logic seen;
        start_v = '0;
        sub_bus = 1'b0;
        a_bus = '0;
        b_bus = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_state dut=%0d", i), 64'(all_zero(i)), 64'd1);
        rst_n = 1'b1;

        run_op(0, 64'h0000_00FF, 64'h0000_0001, 1'b0, 64'h0000_0100, 1'b0, 1'b0);
        run_op(0, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(0, 64'h1234_5678, 64'h1234_5678, 1'b1, 64'd0, 1'b1, 1'b0);
        run_op(0, 64'h7FFF_FFFF, 64'd1, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
        run_op(0, 64'hFFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        run_op(0, 64'h8000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1);
        run_op(0, 64'hDEAD_BEEF, 64'd0, 1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0);

        // asynchronous reset while idle with non-zero result held
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_mid dut=%0d", i), 64'(all_zero(i)), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy_v != 3'b0 || done_v != 3'b0) seen = 1'b1;
        end
        check("idle_no_busy", 64'(seen), 64'd0);
        check("idle_outputs", 64'(all_zero(0)), 64'd1);

        // start held high: back-to-back operations every NCHUNK+1 cycles
        @(negedge clk);
        a_bus = 64'd10;
        b_bus = 64'd3;
        sub_bus = 1'b0;
        start_v[0] = 1'b1;
        push(0, 64'd13, 1'b0, 1'b0);
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            seen = 1'b0;
            while (!seen && n < 50) begin
                @(negedge clk);
                n++;
                seen = done_v[0];
            end
            check("b2b_done", 64'(seen), 64'd1);
            if (k > 0) check("b2b_spacing", 64'(cyc - prev), 64'd5);
            prev = cyc;
            if (k == 0) begin
                a_bus = 64'd100;
                push(0, 64'd103, 1'b0, 1'b0);
            end else if (k == 1) begin
                a_bus = 64'hFFFF_FFFF;
                b_bus = 64'd1;
                push(0, 64'd0, 1'b1, 1'b0);
            end else begin
                start_v[0] = 1'b0;
            end
        end

        // operand changes and start pulse during RUN are ignored
        @(negedge clk);
        a_bus = 64'h100;
        b_bus = 64'h23;
        sub_bus = 1'b0;
        start_v[0] = 1'b1;
        push(0, 64'h123, 1'b0, 1'b0);
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        @(negedge clk);
        a_bus = 64'hFFFF_FFFF;
        b_bus = 64'hFFFF_FFFF;
        sub_bus = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            seen = done_v[0];
        end
        check("ignore_done", 64'(seen), 64'd1);
        repeat (8) @(negedge clk);

        // reset during the second RUN cycle aborts the operation
        @(negedge clk);
        a_bus = 64'h0F0F_0F0F;
        b_bus = 64'h0101_0101;
        sub_bus = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_reset", 64'(all_zero(0)), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_op(0, 64'h1111_1111, 64'h2222_2222, 1'b0, 64'h3333_3333, 1'b0, 1'b0);

        run_op(1, 64'h7FFF, 64'd1, 1'b0, 64'h8000, 1'b0, 1'b1);
        run_op(1, 64'hFFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        run_op(1, 64'd5, 64'd7, 1'b1, 64'hFFFE, 1'b0, 1'b0);
        run_op(1, 64'h8000, 64'd1, 1'b1, 64'h7FFF, 1'b1, 1'b1);
        run_op(1, 64'h1234, 64'h1234, 1'b1, 64'd0, 1'b1, 1'b0);

        run_op(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        run_op(2, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op(2, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run_op(2, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1,
               64'd1, 1'b1, 1'b0);
        run_op(2, 64'h0FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h1000_0000_0000_0000, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
